// File: rtl/strb_to_axis_fifo.sv
// strb_to_axis_fifo: buffers strobed words from a CDC vector stage in a small
// register FIFO and re-presents them as an AXI stream with backpressure.
// Strobes arriving when no slot is free are dropped and flagged (sticky ovf).
// Optional feature macro: STRB_TO_AXIS_FIFO_OVF_COUNT_EN adds a saturating
// drop counter on ovf_count; without it ovf_count is tied to 0.
module strb_to_axis_fifo #(
  parameter int WIDTH         = 2,
  parameter int DEPTH         = 4,
  parameter int OVF_CNT_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       aresetn,
  input  logic                       i_strb,
  input  logic [WIDTH-1:0]           i,
  output logic                       o_tvalid,
  input  logic                       o_tready,
  output logic [WIDTH-1:0]           o_tdata,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       ovf,
  input  logic                       ovf_clr,
  output logic [OVF_CNT_WIDTH-1:0]   ovf_count
);
  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]                  wr_ptr, rd_ptr;
  logic [DEPTH-1:0][WIDTH-1:0]  mem;
  logic                         empty, full, pop, push, drop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign o_tvalid = !empty;
  assign o_tdata  = mem[rd_ptr[AW-1:0]];
  assign level    = wr_ptr - rd_ptr;

  // A pop frees the head slot in the same cycle, so a full FIFO still accepts.
  assign pop  = o_tvalid & o_tready;
  assign push = i_strb & (!full | pop);
  assign drop = i_strb & full & !pop;

  // Pointer update; wrap is plain modulo arithmetic.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage array: one register per entry, written only at the tail slot.
  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_mem
      always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn)
          mem[g] <= '0;
        else if (push && (wr_ptr[AW-1:0] == AW'(g)))
          mem[g] <= i;
      end
    end
  endgenerate

  // Sticky overflow flag; a drop in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn)     ovf <= 1'b0;
    else if (drop)    ovf <= 1'b1;
    else if (ovf_clr) ovf <= 1'b0;
  end

`ifdef STRB_TO_AXIS_FIFO_OVF_COUNT_EN
  logic [OVF_CNT_WIDTH-1:0] cnt;

  // Saturating drop counter; clear restarts at 1 if a drop coincides.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn)
      cnt <= '0;
    else if (ovf_clr)
      cnt <= drop ? OVF_CNT_WIDTH'(1) : '0;
    else if (drop && (cnt != {OVF_CNT_WIDTH{1'b1}}))
      cnt <= cnt + 1'b1;
  end

  assign ovf_count = cnt;
`else
  assign ovf_count = '0;
`endif

endmodule

// File: tb/tb_strb_to_axis_fifo.sv
// Directed bench for strb_to_axis_fifo (WIDTH=2, DEPTH=4, OVF_CNT_WIDTH=8).
module tb_strb_to_axis_fifo;
  logic       clk = 1'b0;
  logic       aresetn = 1'b0;
  logic       i_strb = 1'b0;
  logic [1:0] i = 2'd0;
  logic       o_tvalid;
  logic       o_tready = 1'b0;
  logic [1:0] o_tdata;
  logic [2:0] level;
  logic       ovf;
  logic       ovf_clr = 1'b0;
  logic [7:0] ovf_count;

  int checks = 0;
  int failures = 0;

`ifdef STRB_TO_AXIS_FIFO_OVF_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  strb_to_axis_fifo #(.WIDTH(2), .DEPTH(4), .OVF_CNT_WIDTH(8)) dut (
    .clk(clk), .aresetn(aresetn), .i_strb(i_strb), .i(i),
    .o_tvalid(o_tvalid), .o_tready(o_tready), .o_tdata(o_tdata),
    .level(level), .ovf(ovf), .ovf_clr(ovf_clr), .ovf_count(ovf_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] q[$];
    logic [1:0] prev;
    logic       stall, pm, s, exp_ovf;
    int         n0, sent, cyc;

    // Reset with a strobe held high: it must be ignored.
    i_strb = 1'b1; i = 2'd3;
    step(); step();
    check("rst_tvalid", o_tvalid, 0);
    check("rst_level", level, 0);
    check("rst_ovf", ovf, 0);
    check("rst_tdata", o_tdata, 0);
    check("rst_cnt", ovf_count, 0);

    // Release with o_tready=1: nothing emitted.
    i_strb = 1'b0; o_tready = 1'b1; aresetn = 1'b1;
    step(); step();
    check("idle_tvalid", o_tvalid, 0);
    check("idle_level", level, 0);

    // Single word, one-cycle latency, popped on the next edge.
    i_strb = 1'b1; i = 2'b10;
    step();
    i_strb = 1'b0;
    check("single_tvalid", o_tvalid, 1);
    check("single_tdata", o_tdata, 2'b10);
    check("single_level", level, 1);
    step();
    check("single_pop_tvalid", o_tvalid, 0);
    check("single_pop_level", level, 0);

    // Fill and drop: fifth strobe is dropped.
    o_tready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      i_strb = 1'b1; i = 2'(k);
      step();
    end
    i_strb = 1'b0;
    check("fill_level", level, 4);
    check("fill_ovf", ovf, 1);
    check("fill_cnt", ovf_count, CNT_EN ? 1 : 0);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("clr_ovf", ovf, 0);
    check("clr_cnt", ovf_count, 0);
    o_tready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("drain_tvalid", o_tvalid, 1);
      check("drain_tdata", o_tdata, k);
      step();
    end
    check("drain_empty", o_tvalid, 0);
    check("drain_level", level, 0);

    // Full with simultaneous push and pop.
    o_tready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      i_strb = 1'b1; i = 2'(3 - k);
      step();
    end
    o_tready = 1'b1; i_strb = 1'b1; i = 2'd1;
    step();
    i_strb = 1'b0; o_tready = 1'b0;
    check("pp_level", level, 4);
    check("pp_ovf", ovf, 0);
    o_tready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("pp_tdata", o_tdata, (k == 3) ? 1 : 2 - k);
      step();
    end
    check("pp_empty", o_tvalid, 0);

    // Random backpressure against a queue model.
    exp_ovf = 1'b0; sent = 0; cyc = 0;
    while ((sent < 100 || q.size() != 0) && cyc < 3000) begin
      s = (sent < 100) ? 1'($urandom % 2) : 1'b0;
      i_strb = s; i = 2'($urandom); o_tready = 1'($urandom % 2);
      if (s) sent++;
      n0 = q.size();
      pm = (n0 != 0) && o_tready;
      check("bp_tvalid", o_tvalid, n0 != 0);
      if (pm) check("bp_tdata", o_tdata, q[0]);
      stall = o_tvalid && !o_tready;
      prev = o_tdata;
      step();
      if (pm) void'(q.pop_front());
      if (s && (n0 < 4 || pm)) q.push_back(i);
      else if (s) exp_ovf = 1'b1;
      check("bp_level", level, q.size());
      check("bp_ovf", ovf, exp_ovf);
      if (stall) check("bp_stable", o_tdata, prev);
      cyc++;
    end
    check("bp_done", q.size(), 0);
    i_strb = 1'b0; ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;

    // Clear race: drop coincides with ovf_clr.
    o_tready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      i_strb = 1'b1; i = 2'(k);
      step();
    end
    ovf_clr = 1'b1;
    step();
    i_strb = 1'b0;
    check("race_ovf", ovf, 1);
    check("race_cnt", ovf_count, CNT_EN ? 1 : 0);
    step();
    ovf_clr = 1'b0;
    check("clr2_ovf", ovf, 0);
    check("clr2_cnt", ovf_count, 0);

    // 300 drops saturate the counter.
    i_strb = 1'b1;
    for (int k = 0; k < 300; k++) step();
    i_strb = 1'b0;
    check("sat_cnt", ovf_count, CNT_EN ? 255 : 0);
    check("sat_ovf", ovf, 1);
    check("sat_level", level, 4);
    check("sat_head", o_tdata, 0);

    // Asynchronous reset mid-transfer discards everything.
    #2 aresetn = 1'b0;
    #1;
    check("arst_tvalid", o_tvalid, 0);
    check("arst_level", level, 0);
    check("arst_ovf", ovf, 0);
    check("arst_cnt", ovf_count, 0);
    check("arst_tdata", o_tdata, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
